y_result_collector: RTL and testbench

- Downstream stage of the y = a/(a+d) * b*cos(c) datapath; consumes the 13-bit sign-magnitude result stream {sign, Q0.12 magnitude}.
- Converts each sample to two's complement and averages non-overlapping blocks of ACC_LEN samples.
- Buffers the block means in a small FIFO and offers them to the consumer on a valid/ready interface.
- The producer pipeline cannot stall, so the input side has no ready; loss on overflow is flagged, never back-pressured.

---
 rtl/y_result_collector_pkg.sv | 13 +
 rtl/y_result_collector_fifo.sv | 40 ++++
 rtl/y_result_collector.sv | 70 +++++++
 tb/tb_y_result_collector.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/y_result_collector_pkg.sv
// y_result_collector_pkg: shared widths and sign-magnitude helpers for the y-result stages.
package y_result_collector_pkg;
  localparam int DATAWIDTH_DEF = 12;
  localparam int ACC_LEN_DEF = 4;
  localparam int DEPTH_DEF = 8;
  localparam int SHIFT = $clog2(ACC_LEN_DEF);
  localparam int ACC_W = DATAWIDTH_DEF + 1 + SHIFT;
  localparam int LVL_W = $clog2(DEPTH_DEF) + 1;
  // Negative zero maps to 0; callers truncate to their own width.
  function automatic logic signed [31:0] sm_to_tc(input logic sign, input logic [30:0] mag);
    return sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction
endpackage

// File: rtl/y_result_collector_fifo.sv
// collector_fifo: wrap-bit pointer FIFO with pass-through write when full and popped.
module collector_fifo #(
  parameter int W = 13,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int IW = $clog2(DEPTH);
  logic [IW:0] wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic wr_en, rd_en;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[IW-1:0] == rd_q[IW-1:0]) && (wr_q[IW] != rd_q[IW]);
    rd_en = pop && !empty;
    wr_en = push && (!full || rd_en);
    wr_d = wr_q + {{IW{1'b0}}, wr_en};
    rd_d = rd_q + {{IW{1'b0}}, rd_en};
    level = wr_q - rd_q;
    dout = empty ? '0 : mem_q[rd_q[IW-1:0]];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q[IW-1:0]] <= din;
endmodule

// File: rtl/y_result_collector.sv
// y_result_collector: converts sign-magnitude y samples, block-averages them and buffers the means.
module y_result_collector
  import y_result_collector_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int ACC_LEN = ACC_LEN_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATAWIDTH:0]         y_in,
  input  logic                       y_valid,
  input  logic                       flush,
  input  logic                       clr_ovf,
  input  logic                       out_ready,
  output logic [DATAWIDTH:0]         data_out,
  output logic                       out_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf
);
  localparam int SH = $clog2(ACC_LEN);
  localparam int AW = DATAWIDTH + 1 + SH;
  logic signed [DATAWIDTH:0] conv_q, conv_d;
  logic conv_v_q, conv_v_d;
  logic signed [AW-1:0] acc_q, acc_d, sum;
  logic [SH-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [DATAWIDTH:0] mean;
  logic last, push, pop, full, empty;
  always_comb begin
    conv_d = y_valid ? (DATAWIDTH+1)'(sm_to_tc(y_in[DATAWIDTH], 31'(y_in[DATAWIDTH-1:0]))) : conv_q;
    conv_v_d = y_valid && !flush;
    sum = acc_q + AW'(conv_q);
    last = conv_v_q && (cnt_q == SH'(ACC_LEN - 1));
    push = last && !flush;
    // Arithmetic shift floors the mean toward minus infinity.
    mean = (DATAWIDTH+1)'(sum >>> SH);
    pop = out_ready && !empty;
    acc_d = (flush || last) ? '0 : conv_v_q ? sum : acc_q;
    cnt_d = (flush || last) ? '0 : conv_v_q ? cnt_q + SH'(1) : cnt_q;
    ovf_d = (push && full && !pop) ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
    out_valid = !empty;
    ovf = ovf_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      conv_q <= '0;
      conv_v_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      conv_q <= conv_d;
      conv_v_q <= conv_v_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  collector_fifo #(.W(DATAWIDTH + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (mean),
    .dout  (data_out),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule

// File: tb/tb_y_result_collector.sv
// tb_y_result_collector: scoreboard bench for the block-averaging result collector.
module tb_y_result_collector;
  logic clk = 0;
  logic rst = 1;
  logic [12:0] y_in = '0;
  logic y_valid = 0, flush = 0, clr_ovf = 0, out_ready = 0;
  logic [12:0] data_out;
  logic out_valid, ovf;
  logic [3:0] level;
  logic [12:0] q[$];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  y_result_collector dut (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .flush(flush),
    .clr_ovf(clr_ovf), .out_ready(out_ready), .data_out(data_out),
    .out_valid(out_valid), .level(level), .ovf(ovf)
  );

  function automatic int sm(input logic [12:0] x);
    return x[12] ? -int'(x[11:0]) : int'(x[11:0]);
  endfunction

  function automatic logic [12:0] mean4(input logic [12:0] a, b, c, d);
    int s;
    s = sm(a) + sm(b) + sm(c) + sm(d);
    return 13'(s >>> 2);
  endfunction

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      n_chk++;
      if (q.size() == 0)
        $display("FAIL scoreboard: unexpected output %h, none expected", data_out);
      else begin
        logic [12:0] e;
        e = q.pop_front();
        if (data_out !== e) $display("FAIL scoreboard: data_out=%h expected %h", data_out, e);
        else n_pass++;
      end
    end

  task automatic send(input logic [12:0] x);
    y_valid = 1;
    y_in = x;
    @(posedge clk); #1;
    y_valid = 0;
  endtask

  task automatic send_block(input logic [12:0] a, b, c, d, input bit exp);
    logic [12:0] v[4];
    v = '{a, b, c, d};
    if (exp) q.push_back(mean4(a, b, c, d));
    for (int i = 0; i < 4; i++) begin
      y_valid = 1;
      y_in = v[i];
      @(posedge clk); #1;
    end
    y_valid = 0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && (q.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    n_chk++;
    if (q.size() != 0 || out_valid)
      $display("FAIL %s drain: pending=%0d out_valid=%b expected 0/0", name, q.size(), out_valid);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: %b expected 0", out_valid); else n_pass++;
    n_chk++; if (level !== 4'd0) $display("FAIL reset level: %0d expected 0", level); else n_pass++;
    n_chk++; if (ovf !== 1'b0) $display("FAIL reset ovf: %b expected 0", ovf); else n_pass++;
    n_chk++; if (data_out !== 13'h0) $display("FAIL reset data_out: %h expected 0", data_out); else n_pass++;
  endtask

  task automatic test_average;
    out_ready = 1;
    send_block(13'h0400, 13'h0400, 13'h0400, 13'h0400, 1);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL latency early: out_valid=%b expected 0", out_valid); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 1'b1) $display("FAIL latency: out_valid=%b expected 1", out_valid); else n_pass++;
    n_chk++; if (data_out !== 13'h0400) $display("FAIL average data_out: %h expected 0400", data_out); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (level !== 4'd0) $display("FAIL average level after pop: %0d expected 0", level); else n_pass++;
    wait_drain("average");
  endtask

  task automatic test_mixed_signs;
    out_ready = 1;
    send_block(13'h0064, 13'h1064, 13'h00C8, 13'h10C8, 1);
    send_block(13'h1000, 13'h1000, 13'h1000, 13'h1000, 1);
    wait_drain("mixed");
  endtask

  task automatic test_floor;
    out_ready = 1;
    send_block(13'h1001, 13'h1001, 13'h1001, 13'h0000, 1);
    send_block(13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF, 1);
    wait_drain("floor");
  endtask

  task automatic test_overflow;
    out_ready = 0;
    for (int i = 0; i < 9; i++) send_block(13'h0010, 13'h0010, 13'h0010, 13'h0010, i < 8);
    @(posedge clk); #1;
    n_chk++; if (level !== 4'd8) $display("FAIL overflow level: %0d expected 8", level); else n_pass++;
    n_chk++; if (ovf !== 1'b1) $display("FAIL overflow ovf: %b expected 1", ovf); else n_pass++;
    send_block(13'h0010, 13'h0010, 13'h0010, 13'h0010, 0);
    clr_ovf = 1;
    @(posedge clk); #1;
    clr_ovf = 0;
    n_chk++; if (ovf !== 1'b1) $display("FAIL ovf set-wins: %b expected 1", ovf); else n_pass++;
    clr_ovf = 1;
    @(posedge clk); #1;
    clr_ovf = 0;
    n_chk++; if (ovf !== 1'b0) $display("FAIL clr_ovf: %b expected 0", ovf); else n_pass++;
  endtask

  task automatic test_full_pass_through;
    send_block(13'h0020, 13'h0020, 13'h0020, 13'h0020, 1);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    n_chk++; if (level !== 4'd8) $display("FAIL full+pop level: %0d expected 8", level); else n_pass++;
    n_chk++; if (ovf !== 1'b0) $display("FAIL full+pop ovf: %b expected 0", ovf); else n_pass++;
    out_ready = 1;
    wait_drain("full_pass_through");
  endtask

  task automatic test_flush;
    out_ready = 1;
    y_valid = 1;
    y_in = 13'h0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    y_valid = 0;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    send_block(13'h0020, 13'h0020, 13'h0020, 13'h0020, 1);
    wait_drain("flush");
  endtask

  task automatic test_reset_mid;
    out_ready = 0;
    send_block(13'h0040, 13'h0040, 13'h0040, 13'h0040, 0);
    @(posedge clk); #1;
    n_chk++; if (level !== 4'd1) $display("FAIL pre-reset level: %0d expected 1", level); else n_pass++;
    send(13'h0200);
    send(13'h0200);
    rst = 1;
    #1;
    n_chk++; if (level !== 4'd0) $display("FAIL async reset level: %0d expected 0", level); else n_pass++;
    @(posedge clk); #1;
    rst = 0;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset mid out_valid: %b expected 0", out_valid); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL spurious out_valid: %b expected 0", out_valid); else n_pass++;
    out_ready = 1;
    send_block(13'h0300, 13'h0300, 13'h0300, 13'h0300, 1);
    wait_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_average();
    test_mixed_signs();
    test_floor();
    test_overflow();
    test_full_pass_through();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
